h6_seq_driver: RTL

- Initiator-side sequencer for the H6 multiplier unit: replays the operator entry sequence H6 expects on its 16 one-hot key inputs and control strobes, then collects the result.
- Sits between the datapath controller and the H6 wrapper, so the ALU can issue a 16x16 multiply as a single start/done transaction.
- Drives the H6 key lines (Zero_in..F_in) and inTWO/inTHREE/inFOUR/inQLK.
- Samples A_mul_bus, Q_mul_bus, alu_carryOut and alu_overflowOut back into result registers.

---
 rtl/h6_seq_driver_if.sv | 48 ++++
 rtl/h6_seq_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/h6_seq_driver_if.sv
// ============================================================================
// Module   : h6_seq_driver_if
// Brief    : Handshake, key-line and result bus bundle between the datapath
//            controller, the H6 sequencer and the H6 wrapper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface h6_seq_driver_if;
    logic        start;
    logic        abort;
    logic [15:0] op_m;
    logic [15:0] op_q;
    logic [15:0] key_out;
    logic        inTWO;
    logic        inTHREE;
    logic        inFOUR;
    logic        inQLK;
    logic [15:0] A_mul_bus;
    logic [15:0] Q_mul_bus;
    logic        alu_carryOut;
    logic        alu_overflowOut;
    logic        busy;
    logic        done;
    logic [15:0] res_a;
    logic [15:0] res_q;
    logic        res_c;
    logic        res_v;
    logic [15:0] op_count;
    logic        sticky_v;

    // The sequencer is the master: it drives the H6 keys and the result side
    modport master (
        input  start, abort, op_m, op_q,
        input  A_mul_bus, Q_mul_bus, alu_carryOut, alu_overflowOut,
        output key_out, inTWO, inTHREE, inFOUR, inQLK,
        output busy, done, res_a, res_q, res_c, res_v, op_count, sticky_v
    );

    modport slave (
        output start, abort, op_m, op_q,
        output A_mul_bus, Q_mul_bus, alu_carryOut, alu_overflowOut,
        input  key_out, inTWO, inTHREE, inFOUR, inQLK,
        input  busy, done, res_a, res_q, res_c, res_v, op_count, sticky_v
    );
endinterface

`default_nettype wire

// File: rtl/h6_seq_driver.sv
// ============================================================================
// Module   : h6_seq_driver
// Brief    : Replays the H6 operator key/strobe sequence for one 16x16 multiply
//            and captures the result. Optional macro H6_SEQ_OPCNT_EN adds an
//            operation counter and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module h6_seq_driver #(
    parameter int HOLD_CYC   = 4,
    parameter int GAP_CYC    = 2,
    parameter int STEP_CNT   = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic            CLK_50,
    input  logic            Rst,
    h6_seq_driver_if.master h6
);

    localparam int C_MAX_A = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int C_MAX   = (C_MAX_A > SETTLE_CYC) ? C_MAX_A : SETTLE_CYC;
    localparam int CNT_W   = $clog2(C_MAX + 1);
    localparam int C_SET_M1 = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] C_HOLD_M1 = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_M1  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_SETL_M1 = CNT_W'(C_SET_M1);
    localparam logic [7:0]       C_STEPS   = 8'(STEP_CNT);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_M   = 4'd1,
        COMMIT_M = 4'd2,
        LOAD_Q   = 4'd3,
        COMMIT_Q = 4'd4,
        RUN      = 4'd5,
        STEP     = 4'd6,
        SETTLE   = 4'd7,
        CAPTURE  = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       nib_q, nib_d;
    logic [7:0]       step_q, step_d;
    logic [15:0]      m_q, m_d, q_q, q_d;
    logic [15:0]      key_out_q, key_out_d;
    logic             two_q, two_d, three_q, three_d;
    logic             four_q, four_d, qlk_q, qlk_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [15:0]      res_a_q, res_a_d, res_q_q, res_q_d;
    logic             res_c_q, res_c_d, res_v_q, res_v_d;
    logic [15:0]      w_op;
    logic [15:0]      w_sh;

    // Next-state logic: each key/strobe slot is a hold phase then a gap phase
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        step_d  = step_q;
        m_d     = m_q;
        q_d     = q_q;
        if (h6.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (h6.start) begin
                        m_d     = h6.op_m;
                        q_d     = h6.op_q;
                        state_d = LOAD_M;
                        hold_d  = 1'b1;
                        cnt_d   = C_HOLD_M1;
                        nib_d   = 2'd0;
                    end
                end
                LOAD_M, COMMIT_M, LOAD_Q, COMMIT_Q, RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (hold_q) begin
                        hold_d = 1'b0;
                        cnt_d  = C_GAP_M1;
                    end else begin
                        hold_d = 1'b1;
                        cnt_d  = C_HOLD_M1;
                        case (state_q)
                            LOAD_M: begin
                                if (nib_q == 2'd3) state_d = COMMIT_M;
                                else               nib_d   = nib_q + 2'd1;
                            end
                            COMMIT_M: begin
                                state_d = LOAD_Q;
                                nib_d   = 2'd0;
                            end
                            LOAD_Q: begin
                                if (nib_q == 2'd3) state_d = COMMIT_Q;
                                else               nib_d   = nib_q + 2'd1;
                            end
                            COMMIT_Q: state_d = RUN;
                            default: begin
                                state_d = STEP;
                                step_d  = C_STEPS;
                            end
                        endcase
                    end
                end
                STEP: begin
                    if (hold_q) begin
                        hold_d = 1'b0;
                    end else begin
                        step_d = step_q - 8'd1;
                        if (step_q == 8'd1) begin
                            state_d = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;
                            cnt_d   = C_SETL_M1;
                        end else begin
                            hold_d = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    else             state_d = CAPTURE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered with it
    always_comb begin
        w_op      = (state_d == LOAD_M) ? m_d : q_d;
        w_sh      = w_op >> {2'd3 - nib_d, 2'b00};
        key_out_d = (hold_d && (state_d == LOAD_M || state_d == LOAD_Q))
                    ? (16'd1 << w_sh[3:0]) : 16'd0;
        two_d     = hold_d && (state_d == COMMIT_M);
        three_d   = hold_d && (state_d == COMMIT_Q);
        four_d    = hold_d && (state_d == RUN);
        qlk_d     = hold_d && (state_d == STEP);
        busy_d    = (state_d != IDLE) && (state_d != CAPTURE);
        done_d    = (state_d == CAPTURE);
        res_a_d   = done_d ? h6.A_mul_bus       : res_a_q;
        res_q_d   = done_d ? h6.Q_mul_bus       : res_q_q;
        res_c_d   = done_d ? h6.alu_carryOut    : res_c_q;
        res_v_d   = done_d ? h6.alu_overflowOut : res_v_q;
    end

    always_ff @(posedge CLK_50 or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            hold_q    <= 1'b0;
            cnt_q     <= '0;
            nib_q     <= 2'd0;
            step_q    <= 8'd0;
            m_q       <= 16'd0;
            q_q       <= 16'd0;
            key_out_q <= 16'd0;
            two_q     <= 1'b0;
            three_q   <= 1'b0;
            four_q    <= 1'b0;
            qlk_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_a_q   <= 16'd0;
            res_q_q   <= 16'd0;
            res_c_q   <= 1'b0;
            res_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            nib_q     <= nib_d;
            step_q    <= step_d;
            m_q       <= m_d;
            q_q       <= q_d;
            key_out_q <= key_out_d;
            two_q     <= two_d;
            three_q   <= three_d;
            four_q    <= four_d;
            qlk_q     <= qlk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_a_q   <= res_a_d;
            res_q_q   <= res_q_d;
            res_c_q   <= res_c_d;
            res_v_q   <= res_v_d;
        end
    end

    assign h6.key_out = key_out_q;
    assign h6.inTWO   = two_q;
    assign h6.inTHREE = three_q;
    assign h6.inFOUR  = four_q;
    assign h6.inQLK   = qlk_q;
    assign h6.busy    = busy_q;
    assign h6.done    = done_q;
    assign h6.res_a   = res_a_q;
    assign h6.res_q   = res_q_q;
    assign h6.res_c   = res_c_q;
    assign h6.res_v   = res_v_q;

`ifdef H6_SEQ_OPCNT_EN
    logic [15:0] op_count_q, op_count_d;
    logic        sticky_v_q, sticky_v_d;

    // Aborts never reach CAPTURE, so they are excluded automatically
    always_comb begin
        op_count_d = op_count_q;
        sticky_v_d = sticky_v_q;
        if (state_d == CAPTURE) begin
            if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
            if (h6.alu_overflowOut)     sticky_v_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_50 or negedge Rst) begin
        if (!Rst) begin
            op_count_q <= 16'd0;
            sticky_v_q <= 1'b0;
        end else begin
            op_count_q <= op_count_d;
            sticky_v_q <= sticky_v_d;
        end
    end

    assign h6.op_count = op_count_q;
    assign h6.sticky_v = sticky_v_q;
`else
    assign h6.op_count = 16'd0;
    assign h6.sticky_v = 1'b0;
`endif

endmodule

`default_nettype wire
